// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared FSM state type and widths for the enc8to3_scan slice
package enc_pkg;

  localparam int IN_W  = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/pri_enc8.sv
// rtl/pri_enc8.sv - 8-bit priority select with single-bit-set flag; scan order set by ENC_MSB_FIRST_EN
module pri_enc8
  import enc_pkg::*;
(
  input  logic [IN_W-1:0]  vec,
  output logic [IDX_W-1:0] idx,
  output logic             single
);

  // Pick the next bit to report; the loop direction makes the last hit win.
  always_comb begin
    idx = '0;
`ifdef ENC_MSB_FIRST_EN
    for (int i = 0; i < IN_W; i++) begin
      if (vec[i]) idx = IDX_W'(i);
    end
`else
    for (int i = IN_W - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
`endif
  end

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  always_comb begin
    single = (vec != '0) && ((vec & (vec - IN_W'(1))) == '0);
  end

endmodule

// File: rtl/enc8to3_scan.sv
// rtl/enc8to3_scan.sv - captures a multi-hot vector and streams its set-bit indices (order via ENC_MSB_FIRST_EN in pri_enc8)
module enc8to3_scan
  import enc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in,
  input  logic             en,
  output logic             in_rdy,
  output logic [IDX_W-1:0] out,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             out_last
);

  state_t            state;
  state_t            state_nxt;
  logic [IN_W-1:0]   pend;
  logic [IN_W-1:0]   pend_nxt;
  logic [IDX_W-1:0]  sel_idx;
  logic              sel_one;
  logic [IN_W-1:0]   clr_mask;

  pri_enc8 u_pri (
    .vec    (pend),
    .idx    (sel_idx),
    .single (sel_one)
  );

  assign clr_mask = IN_W'(1) << sel_idx;

  // State and pending-bit register; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pend  <= '0;
    end else begin
      state <= state_nxt;
      pend  <= pend_nxt;
    end
  end

  // Next state, pending update and handshake outputs; pending is empty whenever in IDLE.
  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    in_rdy    = 1'b0;
    out_vld   = 1'b0;
    out       = '0;
    out_last  = 1'b0;
    case (state)
      IDLE: begin
        in_rdy = 1'b1;
        // An all-zero vector is consumed without producing any beat.
        if (en && (in != '0)) begin
          pend_nxt  = in;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        out_vld  = 1'b1;
        out      = sel_idx;
        out_last = sel_one;
        if (out_rdy) begin
          pend_nxt = pend & ~clr_mask;
          if (sel_one) state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        pend_nxt  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_enc8to3_scan.sv
// tb/tb_enc8to3_scan.sv - randomized self-checking bench for enc8to3_scan against a set-bit list model
module tb_enc8to3_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in;
  logic       en;
  logic       in_rdy;
  logic [2:0] out;
  logic       out_vld;
  logic       out_rdy;
  logic       out_last;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] exp_q[$];
  logic [5:0] obs;
  logic [5:0] exp_v;

  localparam logic [5:0] IDLE_OBS = 6'b01_000_0;

  enc8to3_scan dut (
    .clk      (clk),
    .rst      (rst),
    .in       (in),
    .en       (en),
    .in_rdy   (in_rdy),
    .out      (out),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  assign obs = {out_vld, in_rdy, out, out_last};

  // Expected beat list: every set bit index, in scan order.
  function automatic void model(input logic [7:0] v);
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
`ifdef ENC_MSB_FIRST_EN
        exp_q.push_front(3'(i));
`else
        exp_q.push_back(3'(i));
`endif
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one vector from IDLE and follow every beat; rdy_rand randomizes out_rdy and junk on in/en.
  task automatic run_vector(input logic [7:0] v, input bit rdy_rand, input string name);
    int k;
    int cyc;
    n_checks++;
    if (obs !== IDLE_OBS) begin
      n_fail++;
      $display("FAIL %s pre-idle: got %b want %b", name, obs, IDLE_OBS);
    end
    model(v);
    in = v;
    en = 1'b1;
    step();
    en = 1'b0;
    k = 0;
    cyc = 0;
    while (k < exp_q.size() && cyc < 200) begin
      out_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rdy_rand) begin
        en = 1'($urandom_range(0, 1));
        in = 8'($urandom);
      end
      exp_v = {1'b1, 1'b0, exp_q[k], (k == exp_q.size() - 1)};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL %s beat%0d: got %b want %b", name, k, obs, exp_v);
      end
      step();
      if (out_rdy) k++;
      cyc++;
    end
    en = 1'b0;
    out_rdy = 1'b1;
    n_checks++;
    if (cyc >= 200) begin
      n_fail++;
      $display("FAIL %s timeout: got %0d beats want %0d", name, k, exp_q.size());
    end
    n_checks++;
    if (obs !== IDLE_OBS) begin
      n_fail++;
      $display("FAIL %s post-idle: got %b want %b", name, obs, IDLE_OBS);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; in = 8'hFF; out_rdy = 1'b1;
    step();
    step();
    n_checks++;
    if (obs !== IDLE_OBS) begin
      n_fail++;
      $display("FAIL reset: got %b want %b", obs, IDLE_OBS);
    end
    rst = 1'b0; en = 1'b0;
    run_vector(8'hA5, 1'b0, "scan_a5");
  endtask

  task automatic test_backpressure();
    model(8'h81);
    in = 8'h81; en = 1'b1; out_rdy = 1'b0;
    step();
    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      exp_v = {2'b10, exp_q[0], 1'b0};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got %b want %b", c, obs, exp_v);
      end
      step();
    end
    out_rdy = 1'b1;
    for (int k = 0; k < 2; k++) begin
      exp_v = {2'b10, exp_q[k], (k == 1)};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL bp_beat%0d: got %b want %b", k, obs, exp_v);
      end
      step();
    end
    n_checks++;
    if (obs !== IDLE_OBS) begin
      n_fail++;
      $display("FAIL bp_idle: got %b want %b", obs, IDLE_OBS);
    end
  endtask

  task automatic test_boundary();
    in = 8'h00; en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if (obs !== IDLE_OBS) begin
        n_fail++;
        $display("FAIL zero_vec%0d: got %b want %b", c, obs, IDLE_OBS);
      end
    end
    en = 1'b0;
    run_vector(8'h80, 1'b0, "single_80");
  endtask

  task automatic test_full();
    run_vector(8'hFF, 1'b0, "full_ff");
  endtask

  task automatic test_reset_mid_scan();
    model(8'hFF);
    in = 8'hFF; en = 1'b1; out_rdy = 1'b1;
    step();
    en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp_v = {2'b10, exp_q[k], 1'b0};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL mid_beat%0d: got %b want %b", k, obs, exp_v);
      end
      step();
    end
    rst = 1'b1; en = 1'b1; in = 8'h0F;
    step();
    rst = 1'b0; en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (obs !== IDLE_OBS) begin
        n_fail++;
        $display("FAIL mid_rst_idle%0d: got %b want %b", c, obs, IDLE_OBS);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] a[$];
    logic [2:0] b[$];
    model(8'h03); a = exp_q;
    model(8'h0C); b = exp_q;
    in = 8'h03; en = 1'b1; out_rdy = 1'b1;
    step();
    in = 8'h0C;
    for (int k = 0; k < 2; k++) begin
      exp_v = {2'b10, a[k], (k == 1)};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL b2b_a%0d: got %b want %b", k, obs, exp_v);
      end
      step();
    end
    n_checks++;
    if (obs !== IDLE_OBS) begin
      n_fail++;
      $display("FAIL b2b_gap: got %b want %b", obs, IDLE_OBS);
    end
    step();
    en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp_v = {2'b10, b[k], (k == 1)};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL b2b_b%0d: got %b want %b", k, obs, exp_v);
      end
      step();
    end
    n_checks++;
    if (obs !== IDLE_OBS) begin
      n_fail++;
      $display("FAIL b2b_end: got %b want %b", obs, IDLE_OBS);
    end
  endtask

  task automatic test_random();
    logic [7:0] v;
    for (int t = 0; t < 40; t++) begin
      v = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      if (v == 8'h00) begin
        in = v; en = 1'b1;
        step();
        en = 1'b0;
        n_checks++;
        if (obs !== IDLE_OBS) begin
          n_fail++;
          $display("FAIL rand_zero%0d: got %b want %b", t, obs, IDLE_OBS);
        end
      end else begin
        run_vector(v, 1'b1, $sformatf("rand%0d_%02h", t, v));
      end
    end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_boundary();
    test_full();
    test_reset_mid_scan();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
